activation_unit: RTL and testbench
==================================

# activation_unit

Fixed-point activation block for the MobileNetV3-small datapath. It applies ReLU, hard-swish and hard-sigmoid to one signed sample per clock and registers all three results in parallel. Downstream logic selects the result it needs: ReLU for early bottlenecks, hard-swish for later bottlenecks, hard-sigmoid for squeeze-excite gating. The block is purely a per-sample pipeline stage with no inter-sample state.

## Interface
Parameters:
- DATA_WIDTH, 8, total bits of every data port (signed two's complement).
- FRAC_BITS, 4, fractional bits; format is Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS. Constraint: DATA_WIDTH-FRAC_BITS >= 4, so that +6.0 is representable.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- in_valid  input  1  data_in is valid this cycle.
- data_in  input  DATA_WIDTH  signed sample x.
- out_valid  output  1  registered copy of in_valid.
- relu_out  output  DATA_WIDTH  signed ReLU(x).
- hswish_out  output  DATA_WIDTH  signed hard-swish(x).
- hsigmoid_out  output  DATA_WIDTH  signed hard-sigmoid(x), range 0..ONE.

## Operation
- Constants, in raw integers: ONE = 2^FRAC_BITS, THREE = 3*ONE, SIX = 6*ONE.
- ReLU: relu = x if x > 0, else 0. Exact; no rounding.
- Shared clamp term: t = min(max(x + THREE, 0), SIX).
  - Compute x + THREE in at least DATA_WIDTH+1 bits so it cannot overflow.
  - 0 <= t <= SIX.
- Hard-sigmoid: hsigmoid = (t + 3) / 6, using integer division on a non-negative operand.
  - This is t/6 rounded to nearest, ties upward.
  - Output range 0..ONE.
- Hard-swish:
  - p = x * t, as a signed full-precision product of at least DATA_WIDTH + (DATA_WIDTH-FRAC_BITS+FRAC_BITS+1) bits.
  - hswish = p / SIX, rounded to nearest with ties away from zero.
  - Then saturate to the signed DATA_WIDTH range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Division by a constant may use any structure (reciprocal multiply, LUT, etc.). The result must be bit-exact to the definitions above for every input code.
- All three results are computed for every sample, regardless of in_valid.
- in_valid only qualifies out_valid; data registers load every cycle.

## Timing
- Latency: exactly 1 cycle.
  - Values on data_in/in_valid sampled at rising edge N appear on the outputs after edge N.
  - They hold until edge N+1.
- Throughput: one sample per cycle, with no stalls and no backpressure.
- Reset (rst=0): out_valid, relu_out, hswish_out and hsigmoid_out are all 0, asynchronously and while held.
- Reset release: the first rising edge with rst=1 captures the current data_in.
- Reset asserted mid-stream: in-flight results are discarded, and outputs drop to 0 immediately.
- Outputs are driven only from registers; there is no combinational path from data_in to any output.
- The outputs are stable for a full cycle, so a checker sampling 2 cycles after an input change observes the settled result.

## Test plan
Values below are for Q4.4 (DATA_WIDTH=8, FRAC_BITS=4).
- Reset: hold rst=0 for 10 cycles with data_in=32.
  - All outputs and out_valid are 0.
  - Release rst; one edge later relu_out=32.
- Zero: x=0 -> relu=0, hswish=0, hsigmoid=8 (0.5).
- Positive: x=32 (2.0) -> relu=32, hswish=27 (2560/96=26.67 rounds to 27), hsigmoid=13 (80/6).
- Negative:
  - x=-16 (-1.0) -> relu=0, hswish=-5 (-512/96), hsigmoid=5 (32/6=5.33 rounds to 5).
  - x=-48 (-3.0) -> relu=0, hswish=0, hsigmoid=0.
- Saturation of the clamp:
  - x=127 -> relu=127, hswish=127, hsigmoid=16.
  - x=-128 -> all outputs 0.
  - x=48 (3.0) -> hswish=48, hsigmoid=16.
- Streaming: drive x=0,32,-16,-48 on consecutive cycles with in_valid=1, then in_valid=0.
  - Outputs follow one cycle later, back-to-back, with the values above.
  - out_valid is high for 4 cycles, then 0.
  - Assert rst=0 mid-stream: outputs go to 0 before the next clock edge.

Source files
------------

// File: rtl/activation_unit.sv
// Fixed-point ReLU / hard-swish / hard-sigmoid stage: one signed sample per clock,
// all three results registered in parallel with a one-cycle latency.
module activation_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] relu_out,
  output logic signed [DATA_WIDTH-1:0] hswish_out,
  output logic signed [DATA_WIDTH-1:0] hsigmoid_out
);

  localparam int XW  = DATA_WIDTH + 2;
  localparam int PW  = 2 * XW;
  localparam int ONE = 1 << FRAC_BITS;

  localparam logic signed [XW-1:0] THREE_C = XW'(3 * ONE);
  localparam logic signed [XW-1:0] SIX_C   = XW'(6 * ONE);
  localparam logic        [PW-1:0] HALF_P  = PW'(3 * ONE);
  localparam logic        [PW-1:0] SIX_P   = PW'(6 * ONE);
  localparam logic signed [PW-1:0] SAT_MAX = PW'((longint'(1) <<< (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [XW-1:0]         x_ext;
  logic signed [XW-1:0]         xp3;
  logic signed [XW-1:0]         t;
  logic        [PW-1:0]         p;
  logic        [PW-1:0]         mag;
  logic        [PW-1:0]         quo;
  logic signed [PW-1:0]         sq;
  logic signed [PW-1:0]         sat;
  logic        [XW-1:0]         hsig_w;

  logic                         valid_d, valid_q;
  logic signed [DATA_WIDTH-1:0] relu_d, relu_q;
  logic signed [DATA_WIDTH-1:0] hsw_d, hsw_q;
  logic signed [DATA_WIDTH-1:0] hsig_d, hsig_q;

  always_comb begin
    x_ext = {{2{data_in[DATA_WIDTH-1]}}, data_in};
    xp3   = x_ext + THREE_C;

    t = xp3;
    if (xp3 < 0) begin
      t = '0;
    end else if (xp3 > SIX_C) begin
      t = SIX_C;
    end

    // Low PW bits of the product are sign-correct; t is non-negative so zero-extend it.
    p   = {{XW{x_ext[XW-1]}}, x_ext} * {{XW{1'b0}}, t};
    mag = p[PW-1] ? -p : p;
    quo = (mag + HALF_P) / SIX_P;
    sq  = p[PW-1] ? -$signed(quo) : $signed(quo);

    sat = sq;
    if (sq > SAT_MAX) begin
      sat = SAT_MAX;
    end else if (sq < SAT_MIN) begin
      sat = SAT_MIN;
    end

    hsig_w  = ($unsigned(t) + XW'(3)) / XW'(6);

    valid_d = in_valid;
    relu_d  = data_in[DATA_WIDTH-1] ? '0 : data_in;
    hsw_d   = DATA_WIDTH'(sat);
    hsig_d  = DATA_WIDTH'(hsig_w);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      relu_q  <= '0;
      hsw_q   <= '0;
      hsig_q  <= '0;
    end else begin
      valid_q <= valid_d;
      relu_q  <= relu_d;
      hsw_q   <= hsw_d;
      hsig_q  <= hsig_d;
    end
  end

  assign out_valid    = valid_q;
  assign relu_out     = relu_q;
  assign hswish_out   = hsw_q;
  assign hsigmoid_out = hsig_q;

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit (Q4.4): directed vectors, streaming and
// reset sequences, then a full input sweep with random in_valid against a model.
module tb_activation_unit;

  localparam int DW  = 8;
  localparam int FW  = 4;
  localparam int ONE = 1 << FW;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] data_in;
  logic                 out_valid;
  logic signed [DW-1:0] relu_out;
  logic signed [DW-1:0] hswish_out;
  logic signed [DW-1:0] hsigmoid_out;

  int tests;
  int failed;

  activation_unit #(.DATA_WIDTH(DW), .FRAC_BITS(FW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .relu_out     (relu_out),
    .hswish_out   (hswish_out),
    .hsigmoid_out (hsigmoid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int relu;
    int hsw;
    int hsig;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int v, input int r, input int hs, input int hg);
    check({tag, ".valid"}, int'(out_valid), v);
    check({tag, ".relu"},  int'(relu_out), r);
    check({tag, ".hswish"}, int'(hswish_out), hs);
    check({tag, ".hsig"},  int'(hsigmoid_out), hg);
  endtask

  // Reference from the arithmetic definitions, using plain integers.
  function automatic void model(input int x, output int r, output int hs, output int hg);
    int t;
    int p;
    t = x + 3 * ONE;
    if (t < 0) t = 0;
    if (t > 6 * ONE) t = 6 * ONE;
    r  = (x > 0) ? x : 0;
    hg = (t + 3) / 6;
    p  = x * t;
    if (p >= 0) hs = (p + 3 * ONE) / (6 * ONE);
    else        hs = -((-p + 3 * ONE) / (6 * ONE));
    if (hs > (1 << (DW - 1)) - 1) hs = (1 << (DW - 1)) - 1;
    if (hs < -(1 << (DW - 1)))    hs = -(1 << (DW - 1));
  endfunction

  task automatic apply(input int x, input logic v);
    @(negedge clk);
    data_in  = DW'(x);
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[9];
    int   stream_x[4];
    int   r, hs, hg;
    logic v;

    tests    = 0;
    failed   = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    data_in  = 8'sd32;

    vecs[0] = '{x:    0, relu:   0, hsw:   0, hsig:  8};
    vecs[1] = '{x:   32, relu:  32, hsw:  27, hsig: 13};
    vecs[2] = '{x:  -16, relu:   0, hsw:  -5, hsig:  5};
    vecs[3] = '{x:  -48, relu:   0, hsw:   0, hsig:  0};
    vecs[4] = '{x:  127, relu: 127, hsw: 127, hsig: 16};
    vecs[5] = '{x: -128, relu:   0, hsw:   0, hsig:  0};
    vecs[6] = '{x:   48, relu:  48, hsw:  48, hsig: 16};
    vecs[7] = '{x:    1, relu:   1, hsw:   1, hsig:  8};
    vecs[8] = '{x:   -1, relu:   0, hsw:   0, hsig:  8};

    // Reset held with live input
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_out("reset_hold", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_out("reset_release", 1, 32, 27, 13);

    // Directed table
    foreach (vecs[i]) begin
      apply(vecs[i].x, 1'b1);
      check_out($sformatf("vec_x%0d", vecs[i].x), 1, vecs[i].relu, vecs[i].hsw, vecs[i].hsig);
    end

    // Back-to-back stream, then valid drops
    stream_x = '{0, 32, -16, -48};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        apply(stream_x[i], 1'b1);
        check_out($sformatf("stream%0d", i), 1, vecs[i].relu, vecs[i].hsw, vecs[i].hsig);
      end else begin
        apply(32, 1'b0);
        check_out($sformatf("stream%0d", i), 0, 32, 27, 13);
      end
    end

    // Asynchronous reset mid-stream: outputs clear before the next edge
    apply(127, 1'b1);
    check_out("pre_async", 1, 127, 127, 16);
    #2;
    rst = 1'b0;
    #1;
    check_out("async_reset", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check_out("async_held", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // Full code sweep with random in_valid against the model
    for (int x = -128; x < 128; x++) begin
      v = 1'($urandom_range(0, 1));
      apply(x, v);
      model(x, r, hs, hg);
      check_out($sformatf("sweep_x%0d", x), int'(v), r, hs, hg);
    end

    // Random samples
    for (int k = 0; k < 200; k++) begin
      int x;
      x = int'($urandom_range(0, 255)) - 128;
      v = 1'($urandom_range(0, 1));
      apply(x, v);
      model(x, r, hs, hg);
      check_out($sformatf("rand%0d_x%0d", k, x), int'(v), r, hs, hg);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
